el2_exu_div_noc_ctrl: RTL and testbench
=======================================

# el2_exu_div_noc_ctrl

Sequencing controller for the remote divider in the EXU NoC subsystem: accepts one divide request at a time from the EXU and drives the divider serial sender (enable/flush). It then waits for the tagged result packet from the divider wrapper and returns the quotient/remainder to the EXU. It handles cancel, stale-response filtering and a response timeout. It sits between the EXU divide issue logic and the divider sender/receiver NoC wrappers.

## Interface
Parameters:
- TAG_W, 4, width of the transaction tag carried in request and response packets
- TIMEOUT, 1023, WAIT-state cycle limit before abandoning a request (1..2^16-1)

Ports:
- clk  in  1  NoC-side EXU clock
- rst  in  1  reset; asynchronous, active-high
- req_valid  in  1  divide request, one-cycle qualifier
- req_ctl  in  2  {rem, unsign} control bits of the request
- req_dividend  in  32  numerator
- req_divisor  in  32  denominator
- cancel  in  1  EXU kill of the current divide
- snd_enable  out  1  sender enable (packet valid)
- snd_flush  out  1  sender flush, one-cycle pulse
- snd_ack  in  1  sender has accepted the packet
- snd_ctl  out  2  latched req_ctl
- snd_dividend  out  32  latched dividend
- snd_divisor  out  32  latched divisor
- snd_tag  out  TAG_W  tag of the current transaction
- rsp_valid  in  1  result packet received
- rsp_tag  in  TAG_W  tag in the result packet
- rsp_data  in  32  result value
- busy  out  1  controller not IDLE; EXU must stall new divides
- finish  out  1  one-cycle pulse, result valid
- result  out  32  divide result, held until the next finish
- timeout_err  out  1  one-cycle pulse on timeout

## Operation
- States: IDLE, SEND, FLUSH, WAIT.
- IDLE: if req_valid and not cancel:
  - latch ctl/dividend/divisor;
  - tag <= tag+1 (wraps modulo 2^TAG_W);
  - go to SEND.
- IDLE: req_valid with cancel in the same cycle is dropped.
- SEND: snd_enable=1 and operands held stable.
  - snd_ack -> FLUSH.
  - cancel (ack not seen) -> FLUSH with abort flag set.
  - If ack and cancel coincide, ack has priority; the abort flag is set, so the result will be discarded.
- FLUSH: snd_flush=1 for exactly one cycle, snd_enable=0.
  - Abort flag clear -> WAIT.
  - Abort flag set -> IDLE; abort flag cleared.
- WAIT: timer counts from 0.
  - rsp_valid with rsp_tag==snd_tag: result <= rsp_data, finish pulse, go to IDLE.
  - rsp_valid with a mismatched tag: ignored, no state change.
  - cancel: go to IDLE without finish. Any later response carries an old tag and is discarded once the tag advances.
  - timer==TIMEOUT-1 without a match: timeout_err pulse, go to IDLE.
  - Matching rsp_valid and cancel in the same cycle: cancel wins, no finish.
- req_valid while busy is ignored; the EXU is responsible for holding it.
- busy = (state != IDLE).
- Responses arriving in IDLE/SEND/FLUSH are ignored.

## Timing
- Reset values:
  - state IDLE, tag 0, timer 0, abort flag 0;
  - snd_enable/snd_flush/finish/timeout_err/busy 0;
  - snd_ctl/snd_dividend/snd_divisor/result 0.
- All outputs are registered or decoded only from registered state; no combinational path from any input to any output.
- Latency with the request accepted at edge N:
  - busy and snd_enable high in cycle N+1.
  - With ack in cycle N+k, snd_flush is high in cycle N+k+1 and WAIT is entered at N+k+2.
  - A matching rsp_valid in cycle M gives finish=1 and result valid in cycle M+1, with busy=0 in the same cycle. A new request is accepted at that edge.
- Minimum turnaround is 4 cycles (SEND, FLUSH, WAIT, IDLE) with single-cycle ack and response.
- Timeout: if no match arrives, timeout_err is high exactly TIMEOUT cycles after WAIT entry.
- Tag wrap-around: 2^TAG_W-1 -> 0 is legal. Only TAG_W-bit equality is used.
- Asynchronous reset mid-transaction: immediate return to reset values. No flush pulse is generated.

## Test plan
- Basic divide: req dividend=100, divisor=7, ctl=00. Ack after 3 cycles, then rsp tag=1, data=14 -> snd_tag=1, one snd_flush pulse, then finish=1 with result=14; busy low the same cycle.
- Stale filtering: cancel in WAIT, then new req (tag 2). Inject rsp tag=1, data=0xDEAD -> ignored. Then rsp tag=2, data=5 -> result=5, exactly one finish.
- Cancel in SEND before ack -> snd_enable drops, one snd_flush pulse, IDLE, no finish; next request gets tag+1.
- Timeout with TIMEOUT=8 and no response -> timeout_err high exactly 8 cycles after WAIT entry; busy low the next cycle; finish never asserts.
- Tag wrap with TAG_W=2: 5 back-to-back divides -> tags 1,2,3,0,1, all finishes correct. Simultaneous matching rsp and cancel -> no finish.
- Reset asserted while snd_enable=1 -> all outputs 0 immediately; no spurious finish after release.

Source files
------------

// File: rtl/el2_exu_div_noc_ctrl.sv
// el2_exu_div_noc_ctrl
// Sequences one remote divide at a time: latches the request, drives the
// serial sender (enable, then a one-cycle flush), waits for the tagged
// result packet and hands the result back to the EXU. Cancels, stale
// responses and a missing response (timeout) all return the block to IDLE.
module el2_exu_div_noc_ctrl #(
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [1:0]       req_ctl,
    input  logic [31:0]      req_dividend,
    input  logic [31:0]      req_divisor,
    input  logic             cancel,
    output logic             snd_enable,
    output logic             snd_flush,
    input  logic             snd_ack,
    output logic [1:0]       snd_ctl,
    output logic [31:0]      snd_dividend,
    output logic [31:0]      snd_divisor,
    output logic [TAG_W-1:0] snd_tag,
    input  logic             rsp_valid,
    input  logic [TAG_W-1:0] rsp_tag,
    input  logic [31:0]      rsp_data,
    output logic             busy,
    output logic             finish,
    output logic [31:0]      result,
    output logic             timeout_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        FLUSH = 2'd2,
        WAIT  = 2'd3
    } state_t;

    // Last WAIT cycle count before the request is abandoned.
    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [15:0]       timer_q, timer_d;
    logic              abort_q, abort_d;
    logic [1:0]        ctl_q, ctl_d;
    logic [31:0]       dividend_q, dividend_d;
    logic [31:0]       divisor_q, divisor_d;
    logic [31:0]       result_q, result_d;
    logic              finish_q, finish_d;
    logic              timeout_err_q, timeout_err_d;

    // Next-state and datapath decisions; cancel beats a matching response,
    // and a match beats the timeout on the last WAIT cycle.
    always_comb begin
        state_d       = state_q;
        tag_d         = tag_q;
        timer_d       = timer_q;
        abort_d       = abort_q;
        ctl_d         = ctl_q;
        dividend_d    = dividend_q;
        divisor_d     = divisor_q;
        result_d      = result_q;
        finish_d      = 1'b0;
        timeout_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && !cancel) begin
                    ctl_d      = req_ctl;
                    dividend_d = req_dividend;
                    divisor_d  = req_divisor;
                    tag_d      = tag_q + TAG_W'(1);
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (snd_ack || cancel) begin
                    state_d = FLUSH;
                    abort_d = cancel;
                end
            end
            FLUSH: begin
                if (abort_q) begin
                    state_d = IDLE;
                    abort_d = 1'b0;
                end else begin
                    state_d = WAIT;
                    timer_d = 16'd0;
                end
            end
            WAIT: begin
                timer_d = timer_q + 16'd1;
                if (cancel) begin
                    state_d = IDLE;
                end else if (rsp_valid && (rsp_tag == tag_q)) begin
                    result_d = rsp_data;
                    finish_d = 1'b1;
                    state_d  = IDLE;
                end else if (timer_q == TIMER_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset drops everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            tag_q         <= '0;
            timer_q       <= 16'd0;
            abort_q       <= 1'b0;
            ctl_q         <= 2'd0;
            dividend_q    <= 32'd0;
            divisor_q     <= 32'd0;
            result_q      <= 32'd0;
            finish_q      <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            tag_q         <= tag_d;
            timer_q       <= timer_d;
            abort_q       <= abort_d;
            ctl_q         <= ctl_d;
            dividend_q    <= dividend_d;
            divisor_q     <= divisor_d;
            result_q      <= result_d;
            finish_q      <= finish_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign snd_enable   = (state_q == SEND);
    assign snd_flush    = (state_q == FLUSH);
    assign busy         = (state_q != IDLE);
    assign snd_ctl      = ctl_q;
    assign snd_dividend = dividend_q;
    assign snd_divisor  = divisor_q;
    assign snd_tag      = tag_q;
    assign result       = result_q;
    assign finish       = finish_q;
    assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_el2_exu_div_noc_ctrl.sv
// Testbench for el2_exu_div_noc_ctrl with a 2-bit tag and an 8-cycle timeout.
// Expected results are queued when a matching response is driven and
// popped when the DUT raises finish.
module tb_el2_exu_div_noc_ctrl;

   localparam int TAG_W   = 2;
   localparam int TIMEOUT = 8;

   logic             clk;
   logic             rst;
   logic             req_valid;
   logic [1:0]       req_ctl;
   logic [31:0]      req_dividend;
   logic [31:0]      req_divisor;
   logic             cancel;
   logic             snd_enable;
   logic             snd_flush;
   logic             snd_ack;
   logic [1:0]       snd_ctl;
   logic [31:0]      snd_dividend;
   logic [31:0]      snd_divisor;
   logic [TAG_W-1:0] snd_tag;
   logic             rsp_valid;
   logic [TAG_W-1:0] rsp_tag;
   logic [31:0]      rsp_data;
   logic             busy;
   logic             finish;
   logic [31:0]      result;
   logic             timeout_err;

   int               checks;
   int               errors;
   int               finishCount;
   logic [TAG_W-1:0] expTag;
   logic [31:0]      sb[$];

   el2_exu_div_noc_ctrl #(.TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ctl(req_ctl),
      .req_dividend(req_dividend), .req_divisor(req_divisor),
      .cancel(cancel),
      .snd_enable(snd_enable), .snd_flush(snd_flush), .snd_ack(snd_ack),
      .snd_ctl(snd_ctl), .snd_dividend(snd_dividend), .snd_divisor(snd_divisor),
      .snd_tag(snd_tag),
      .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_data(rsp_data),
      .busy(busy), .finish(finish), .result(result), .timeout_err(timeout_err)
   );

   // Free-running clock, rising edge active.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit so the run can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Scoreboard side: every finish pops one expected result.
   always @(negedge clk) begin
      if (!rst && finish) begin
         finishCount++;
         checkOutput("busy_at_finish", {31'd0, busy}, 32'd0);
         if (sb.size() == 0)
            checkOutput("spurious_finish", {31'd0, finish}, 32'd0);
         else
            checkOutput("result", result, sb.pop_front());
      end
   end

   // Issue one request from IDLE and check the latched operands next cycle.
   task automatic applyStimulus(input logic [1:0] ctl, input logic [31:0] a, input logic [31:0] b);
      @(posedge clk); #1;
      req_valid = 1'b1; req_ctl = ctl; req_dividend = a; req_divisor = b;
      @(posedge clk); #1;
      req_valid = 1'b0;
      expTag = expTag + 2'd1;
      @(negedge clk);
      checkOutput("req_busy", {31'd0, busy}, 32'd1);
      checkOutput("req_enable", {31'd0, snd_enable}, 32'd1);
      checkOutput("req_tag", {30'd0, snd_tag}, {30'd0, expTag});
      checkOutput("req_ctl", {30'd0, snd_ctl}, {30'd0, ctl});
      checkOutput("req_dividend", snd_dividend, a);
      checkOutput("req_divisor", snd_divisor, b);
   endtask

   // Hold off the ack for some cycles, then ack and follow flush into WAIT.
   task automatic ackSend(input int delay);
      for (int i = 0; i < delay; i++) begin
         @(posedge clk);
         @(negedge clk);
         checkOutput("enable_held", {31'd0, snd_enable}, 32'd1);
         checkOutput("no_early_flush", {31'd0, snd_flush}, 32'd0);
      end
      @(posedge clk); #1;
      snd_ack = 1'b1;
      @(posedge clk); #1;
      snd_ack = 1'b0;
      @(negedge clk);
      checkOutput("flush_pulse", {31'd0, snd_flush}, 32'd1);
      checkOutput("enable_drop", {31'd0, snd_enable}, 32'd0);
      @(negedge clk);
      checkOutput("flush_end", {31'd0, snd_flush}, 32'd0);
      checkOutput("wait_busy", {31'd0, busy}, 32'd1);
   endtask

   // Drive one response packet; a matching one queues its expected result.
   task automatic sendRsp(input logic [TAG_W-1:0] tag, input logic [31:0] data, input bit match);
      @(posedge clk); #1;
      rsp_valid = 1'b1; rsp_tag = tag; rsp_data = data;
      if (match) sb.push_back(data);
      @(posedge clk); #1;
      rsp_valid = 1'b0;
   endtask

   logic [TAG_W-1:0] staleTag;
   logic [TAG_W-1:0] wrapTags[5];
   int               fc;

   initial begin
      checks = 0; errors = 0; finishCount = 0; expTag = '0;
      rst = 1'b1; req_valid = 1'b0; req_ctl = 2'd0; req_dividend = 32'd0;
      req_divisor = 32'd0; cancel = 1'b0; snd_ack = 1'b0;
      rsp_valid = 1'b0; rsp_tag = '0; rsp_data = 32'd0;
      wrapTags[0] = 2'd1; wrapTags[1] = 2'd2; wrapTags[2] = 2'd3;
      wrapTags[3] = 2'd0; wrapTags[4] = 2'd1;

      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_enable", {31'd0, snd_enable}, 32'd0);
      checkOutput("rst_flush", {31'd0, snd_flush}, 32'd0);
      checkOutput("rst_finish", {31'd0, finish}, 32'd0);
      checkOutput("rst_timeout", {31'd0, timeout_err}, 32'd0);
      checkOutput("rst_result", result, 32'd0);
      checkOutput("rst_tag", {30'd0, snd_tag}, 32'd0);
      checkOutput("rst_dividend", snd_dividend, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Basic divide 100/7 with a 3-cycle ack delay.
      applyStimulus(2'b00, 32'd100, 32'd7);
      checkOutput("basic_tag", {30'd0, snd_tag}, 32'd1);
      ackSend(3);
      sendRsp(expTag, 32'd14, 1'b1);
      @(negedge clk);
      checkOutput("basic_finish", {31'd0, finish}, 32'd1);
      checkOutput("basic_result", result, 32'd14);
      @(negedge clk);
      checkOutput("finish_one_cycle", {31'd0, finish}, 32'd0);
      checkOutput("result_held", result, 32'd14);

      // Cancel in WAIT, then a stale response for the cancelled tag.
      applyStimulus(2'b10, 32'd50, 32'd9);
      staleTag = expTag;
      ackSend(1);
      @(posedge clk); #1;
      cancel = 1'b1;
      @(posedge clk); #1;
      cancel = 1'b0;
      @(negedge clk);
      checkOutput("cancel_wait_idle", {31'd0, busy}, 32'd0);
      fc = finishCount;
      applyStimulus(2'b01, 32'd45, 32'd9);
      ackSend(0);
      sendRsp(staleTag, 32'h0000DEAD, 1'b0);
      @(negedge clk);
      checkOutput("stale_ignored", {31'd0, busy}, 32'd1);
      sendRsp(expTag, 32'd5, 1'b1);
      @(negedge clk);
      checkOutput("stale_result", result, 32'd5);
      @(negedge clk);
      checkOutput("one_finish", finishCount, fc + 1);

      // Cancel in SEND before ack.
      fc = finishCount;
      applyStimulus(2'b00, 32'd8, 32'd2);
      @(posedge clk); #1;
      cancel = 1'b1;
      @(posedge clk); #1;
      cancel = 1'b0;
      @(negedge clk);
      checkOutput("cs_enable_drop", {31'd0, snd_enable}, 32'd0);
      checkOutput("cs_flush", {31'd0, snd_flush}, 32'd1);
      @(negedge clk);
      checkOutput("cs_flush_end", {31'd0, snd_flush}, 32'd0);
      checkOutput("cs_idle", {31'd0, busy}, 32'd0);
      checkOutput("cs_no_finish", finishCount, fc);
      applyStimulus(2'b00, 32'd9, 32'd3);
      ackSend(0);
      sendRsp(expTag, 32'd3, 1'b1);
      @(negedge clk);

      // Ack and cancel together: flush, then straight back to IDLE.
      applyStimulus(2'b11, 32'd1, 32'd1);
      @(posedge clk); #1;
      snd_ack = 1'b1; cancel = 1'b1;
      @(posedge clk); #1;
      snd_ack = 1'b0; cancel = 1'b0;
      @(negedge clk);
      checkOutput("ac_flush", {31'd0, snd_flush}, 32'd1);
      @(negedge clk);
      checkOutput("ac_idle", {31'd0, busy}, 32'd0);

      // Timeout with no response.
      fc = finishCount;
      applyStimulus(2'b00, 32'd77, 32'd7);
      ackSend(0);
      for (int j = 1; j <= TIMEOUT; j++) begin
         @(negedge clk);
         checkOutput("timeout_pulse", {31'd0, timeout_err}, (j == TIMEOUT) ? 32'd1 : 32'd0);
      end
      @(negedge clk);
      checkOutput("timeout_end", {31'd0, timeout_err}, 32'd0);
      checkOutput("timeout_busy", {31'd0, busy}, 32'd0);
      checkOutput("timeout_no_finish", finishCount, fc);

      // Matching response and cancel together: no finish.
      fc = finishCount;
      applyStimulus(2'b00, 32'd20, 32'd4);
      ackSend(0);
      @(posedge clk); #1;
      rsp_valid = 1'b1; rsp_tag = expTag; rsp_data = 32'd99; cancel = 1'b1;
      @(posedge clk); #1;
      rsp_valid = 1'b0; cancel = 1'b0;
      @(negedge clk);
      checkOutput("cm_idle", {31'd0, busy}, 32'd0);
      checkOutput("cm_no_finish", {31'd0, finish}, 32'd0);
      @(negedge clk);
      checkOutput("cm_count", finishCount, fc);

      // Asynchronous reset while snd_enable is high.
      applyStimulus(2'b01, 32'd33, 32'd3);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("ar_enable", {31'd0, snd_enable}, 32'd0);
      checkOutput("ar_busy", {31'd0, busy}, 32'd0);
      checkOutput("ar_flush", {31'd0, snd_flush}, 32'd0);
      checkOutput("ar_tag", {30'd0, snd_tag}, 32'd0);
      checkOutput("ar_result", result, 32'd0);
      checkOutput("ar_dividend", snd_dividend, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      expTag = '0;
      fc = finishCount;
      repeat (3) @(negedge clk);
      checkOutput("ar_no_finish", finishCount, fc);
      checkOutput("ar_idle_flush", {31'd0, snd_flush}, 32'd0);

      // Five divides across the 2-bit tag wrap.
      for (int i = 0; i < 5; i++) begin
         applyStimulus(2'b00, 32'(1000 + i), 32'd10);
         checkOutput("wrap_tag", {30'd0, snd_tag}, {30'd0, wrapTags[i]});
         ackSend(0);
         sendRsp(expTag, 32'(100 + i), 1'b1);
         @(negedge clk);
         checkOutput("wrap_result", result, 32'(100 + i));
      end

      @(negedge clk);
      checkOutput("sb_empty", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
